hqm_qed_aw_rf_fifo_ctl: RTL

// - FIFO controller directly upstream of hqm_qed_mem_AW_rf_pg_512x17: drives its we/waddr/wdata and re/raddr.
// - Consumes rdata (1-cycle read latency) and presents entries on a valid/ready pop port.
// - A 2-entry output buffer hides RF latency, sustaining 1 push + 1 pop per clock.
// - Gates all RF access while the power-gated RF is not powered.

---
 rtl/hqm_qed_aw_fifo_pkg.sv | 24 ++
 rtl/hqm_qed_aw_fifo_obuf.sv | 73 +++++++
 rtl/hqm_qed_aw_rf_fifo_ctl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hqm_qed_aw_fifo_pkg.sv
// Shared definitions for the AW register-file FIFO controller.
//   DEPTH : RF entries and total FIFO capacity
//   AW    : RF address width
//   DW    : RF data width
//   PW    : payload width seen on the push/pop ports
// Optional feature macro: HQM_QED_AW_FIFO_PARITY_EN
//   defined   -> PW = DW-1, the top RF bit carries payload parity
//   undefined -> PW = DW, no parity
package hqm_qed_aw_fifo_pkg;

  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 17;

`ifdef HQM_QED_AW_FIFO_PARITY_EN
  localparam int PW    = DW - 1;
`else
  localparam int PW    = DW;
`endif

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/hqm_qed_aw_fifo_obuf.sv
// Two-entry in-order output buffer placed after the RF read port.
// Accepts one captured RF word per cycle and presents the head on a
// valid/ready pop interface; a capture and a pop may occur together.
//   clk, rst   : clock, async active-high reset (control state only)
//   cap_vld    : capture cap_data this cycle
//   cap_data   : RF read payload
//   out_ready  : consumer takes the head when out_valid is high
//   out_valid  : buffer holds at least one entry
//   out_data   : registered head entry
//   obuf_cnt   : number of entries held (0..2)
module hqm_qed_aw_fifo_obuf
  import hqm_qed_aw_fifo_pkg::*;
#(
  parameter int DATA_W = PW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_vld,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        obuf_cnt
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              pop;

  always_comb begin
    pop    = (cnt_q != 2'd0) & out_ready;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({cap_vld, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = cap_data;
        else               tail_d = cap_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = cap_data;
        end else begin
          head_d = tail_q;
          tail_d = cap_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign obuf_cnt  = cnt_q;

endmodule

// File: rtl/hqm_qed_aw_rf_fifo_ctl.sv
// FIFO controller in front of the power-gated 512x17 AW register file.
// Pushes are written straight into the RF; a read is issued whenever the
// output buffer has room for the returning word, and the word is captured
// one cycle after rf_re. All RF traffic stops while mem_pwr_ok is low.
//   clk, rst            : clock (also RF wclk/rclk), async active-high reset
//   in_valid/in_ready/in_data    : push port
//   out_valid/out_ready/out_data : pop port
//   mem_pwr_ok          : RF powered and not isolated
//   count/empty/full    : occupancy (RF + in-flight + output buffer)
//   rf_we/rf_waddr/rf_wdata : RF write port
//   rf_re/rf_raddr      : RF read port; rf_rdata valid the cycle after rf_re
//   par_err             : sticky parity error
// Optional feature macro: HQM_QED_AW_FIFO_PARITY_EN (payload parity in the
// top RF bit, checked on every captured word; par_err is 0 when undefined).
module hqm_qed_aw_rf_fifo_ctl
  import hqm_qed_aw_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  input  logic          mem_pwr_ok,
  output cnt_t          count,
  output logic          empty,
  output logic          full,
  output logic          rf_we,
  output ptr_t          rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_re,
  output ptr_t          rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          par_err
);

`ifdef HQM_QED_AW_FIFO_PARITY_EN
  function automatic logic calc_par(input logic [PW-1:0] d);
    calc_par = ^d;
  endfunction
`endif

  logic       run_q;
  ptr_t       wptr_q, wptr_d;
  ptr_t       rptr_q, rptr_d;
  cnt_t       rf_cnt_q, rf_cnt_d;
  logic       vld_p1, vld_p1_d;
  logic [1:0] obuf_cnt;
  logic [2:0] occ;
  logic       push, pop;

  always_comb begin
    count = rf_cnt_q + cnt_t'(vld_p1) + cnt_t'(obuf_cnt);
    empty = (count == '0);
    full  = (count == cnt_t'(DEPTH));

    // run_q keeps in_ready low while reset is asserted and for the first
    // cycle after release.
    in_ready = run_q & mem_pwr_ok & ~full;
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;

    // Stage p0: push written into the RF; reads issued from committed entries
    rf_we    = push;
    rf_waddr = wptr_q;

    // A pop this cycle frees an output slot in time for the word returning
    // from a read issued now, which is what allows one pop per clock.
    occ   = 3'(obuf_cnt) + 3'(vld_p1) - 3'(pop);
    rf_re = mem_pwr_ok & (rf_cnt_q != '0) & (occ < 3'd2);
    rf_raddr = rptr_q;

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    wptr_d   = push  ? wptr_q + ptr_t'(1) : wptr_q;
    rptr_d   = rf_re ? rptr_q + ptr_t'(1) : rptr_q;
    rf_cnt_d = rf_cnt_q + cnt_t'(push) - cnt_t'(rf_re);
    vld_p1_d = rf_re;
  end

`ifdef HQM_QED_AW_FIFO_PARITY_EN
  logic par_err_q, par_err_d;

  assign rf_wdata = {calc_par(in_data), in_data};

  always_comb begin
    par_err_d = par_err_q | (vld_p1 & (calc_par(rf_rdata[PW-1:0]) != rf_rdata[DW-1]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  assign rf_wdata = in_data;
  assign par_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rf_cnt_q <= '0;
      vld_p1   <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rf_cnt_q <= rf_cnt_d;
      vld_p1   <= vld_p1_d;
    end
  end

  // Stage p1: RF read data returns and is captured regardless of mem_pwr_ok
  hqm_qed_aw_fifo_obuf #(
    .DATA_W (PW)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .cap_vld   (vld_p1),
    .cap_data  (rf_rdata[PW-1:0]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .obuf_cnt  (obuf_cnt)
  );

endmodule
